// File: rtl/omsp_hmac_nbit.sv
// Word-to-byte adapter in front of the byte-serial omsp_hmac core: splits DATA_WIDTH-bit
// words MSB-first into core absorb pulses and gathers digest bytes back into a word.

// Behavioural stand-in for the byte-serial core so the adapter can be built and exercised
// on its own; swap for the real omsp_hmac when integrating.
module omsp_hmac #(
  parameter int KEY_SIZE = 128,
  parameter int LATENCY  = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start_continue,
  input  logic                data_available,
  input  logic [KEY_SIZE-1:0] key,
  input  logic [7:0]          data_in,
  output logic [7:0]          data_out,
  output logic                busy
);
  localparam int TW = $clog2(LATENCY) + 1;

  logic          r_busy;
  logic          r_keyed;
  logic          r_da;
  logic [7:0]    r_in;
  logic [7:0]    r_acc;
  logic [7:0]    r_out;
  logic [TW-1:0] r_timer;
  logic [7:0]    w_key_fold;

  always_comb begin
    // NOTE: default first so every path assigns the variable and no latch is inferred.
    w_key_fold = '0;
    for (int i = 0; i < KEY_SIZE / 8; i++) w_key_fold ^= key[8*i +: 8];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy  <= 1'b0;
      r_keyed <= 1'b0;
      r_da    <= 1'b0;
      r_in    <= '0;
      r_acc   <= '0;
      r_out   <= '0;
      r_timer <= '0;
    end else if (!r_busy) begin
      if (start_continue) begin
        r_busy  <= 1'b1;
        r_da    <= data_available;
        r_in    <= data_in;
        r_timer <= TW'(LATENCY - 1);
      end
    end else if (r_timer != '0) begin
      r_timer <= r_timer - 1'b1;
    end else begin
      // The first absorb after reset loads the key; later ones mix in a data byte.
      r_busy <= 1'b0;
      if (!r_keyed) begin
        r_acc   <= w_key_fold;
        r_keyed <= 1'b1;
      end else if (r_da) begin
        r_acc <= {r_acc[6:0], r_acc[7]} ^ r_in;
      end else begin
        r_out <= r_acc;
        r_acc <= r_acc + 8'h3B;
      end
    end
  end

  assign busy     = r_busy;
  assign data_out = r_out;
endmodule

module omsp_hmac_nbit #(
  parameter int KEY_SIZE   = 128,
  parameter int DATA_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              start_continue,
  input  logic                              data_available,
  input  logic [$clog2(DATA_WIDTH/8):0]     data_len,
  input  logic [KEY_SIZE-1:0]               key,
  input  logic [DATA_WIDTH-1:0]             data_in,
  output logic [DATA_WIDTH-1:0]             data_out,
  output logic                              busy,
  output logic                              done
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LEN_W = $clog2(BYTES) + 1;
  localparam int CNT_W = (LEN_W > 1) ? LEN_W - 1 : 1;

  typedef enum logic [3:0] {
    S_RESET, S_INIT, S_IDLE, S_LOAD, S_FEED, S_WAIT_IN,
    S_REQ_OUT, S_WAIT_OUT, S_STORE, S_FIN
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [LEN_W-1:0]      r_n;
  logic [DATA_WIDTH-1:0] r_word;
  logic [7:0]            r_byte;
  logic                  r_core_sc;
  logic                  r_core_da;
  logic                  r_seen_busy;
  logic                  r_first;
  logic [DATA_WIDTH-1:0] r_data_out;

  logic                  w_accept;
  logic [LEN_W-1:0]      w_n;
  logic                  w_sc_nxt;
  logic                  w_da_nxt;
  logic                  w_core_busy;
  logic                  w_core_done;
  logic [7:0]            w_core_out;

  omsp_hmac #(.KEY_SIZE(KEY_SIZE)) u_core (
    .clk            (clk),
    .reset_n        (reset_n),
    .start_continue (r_core_sc),
    .data_available (r_core_da),
    .key            (key),
    .data_in        (r_byte),
    .data_out       (w_core_out),
    .busy           (w_core_busy)
  );

  assign w_accept    = start_continue && (r_state == S_RESET || r_state == S_IDLE);
  assign w_n         = (data_len == '0 || data_len > LEN_W'(BYTES)) ? LEN_W'(BYTES) : data_len;
  // A core operation is complete only once its busy has been seen high and then low again.
  assign w_core_done = r_seen_busy && !w_core_busy;

  always_comb begin
    w_state_nxt = r_state;
    w_sc_nxt    = 1'b0;
    w_da_nxt    = 1'b0;
    case (r_state)
      S_RESET:    if (start_continue) begin
                    w_state_nxt = S_INIT;
                    w_sc_nxt    = 1'b1;
                    w_da_nxt    = 1'b1;
                  end
      S_INIT:     if (w_core_done) w_state_nxt = S_LOAD;
      S_IDLE:     if (start_continue) w_state_nxt = data_available ? S_LOAD : S_REQ_OUT;
      S_LOAD:     w_state_nxt = S_FEED;
      S_FEED:     begin
                    w_sc_nxt    = 1'b1;
                    w_da_nxt    = 1'b1;
                    w_state_nxt = S_WAIT_IN;
                  end
      S_WAIT_IN:  if (w_core_done) w_state_nxt = (r_cnt == '0) ? S_FIN : S_LOAD;
      S_REQ_OUT:  begin
                    w_sc_nxt    = 1'b1;
                    w_state_nxt = S_WAIT_OUT;
                  end
      S_WAIT_OUT: if (w_core_done) w_state_nxt = S_STORE;
      S_STORE:    w_state_nxt = (r_cnt == '0) ? S_FIN : S_REQ_OUT;
      S_FIN:      w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_RESET;
      r_cnt       <= '0;
      r_n         <= '0;
      r_word      <= '0;
      r_byte      <= '0;
      r_core_sc   <= 1'b0;
      r_core_da   <= 1'b0;
      r_seen_busy <= 1'b0;
      r_first     <= 1'b0;
      r_data_out  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_core_sc <= w_sc_nxt;
      r_core_da <= w_da_nxt;
      if (w_sc_nxt)         r_seen_busy <= 1'b0;
      else if (w_core_busy) r_seen_busy <= 1'b1;

      if (w_accept) begin
        r_n     <= w_n;
        r_word  <= data_in;
        r_first <= 1'b1;
        r_cnt   <= CNT_W'(w_n - 1'b1);
      end

      case (r_state)
        S_LOAD:    r_byte <= r_word[8*r_cnt +: 8];
        S_WAIT_IN: if (w_core_done && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        S_STORE:   begin
                     // The first store of a request also clears the bytes above the count.
                     for (int i = 0; i < BYTES; i++) begin
                       if (CNT_W'(i) == r_cnt)
                         r_data_out[8*i +: 8] <= w_core_out;
                       else if (r_first && LEN_W'(i) >= r_n)
                         r_data_out[8*i +: 8] <= '0;
                     end
                     r_first <= 1'b0;
                     if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                   end
        default:   ;
      endcase
    end
  end

  assign busy     = !(r_state == S_RESET || r_state == S_IDLE || r_state == S_FIN);
  assign done     = (r_state == S_FIN);
  assign data_out = r_data_out;
endmodule
